// File: rtl/mips_pkg.sv
// Shared MIPS32 datapath constants, writeback select encodings and the
// pending-write payload used by the writeback stage.
package mips_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned CNT_W    = 16;

    localparam logic [ADDR_W-1:0] REG_ZERO = ADDR_W'(0);

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_LUI  = 2'b01,
        WB_MEM  = 2'b10,
        WB_LINK = 2'b11
    } wb_sel_e;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } pend_t;

endpackage

// File: rtl/wb_result_mux.sv
// Combinational 4:1 writeback source select.
module wb_result_mux
    import mips_pkg::*;
(
    input  wb_sel_e           sel_i,
    input  logic [DATA_W-1:0] alu_i,
    input  logic [DATA_W-1:0] lui_i,
    input  logic [DATA_W-1:0] mem_i,
    input  logic [DATA_W-1:0] link_i,
    output logic [DATA_W-1:0] result_o
);

    // Pick the result for the selected source; every encoding is legal.
    always_comb begin
        result_o = alu_i;
        case (sel_i)
            WB_ALU:  result_o = alu_i;
            WB_LUI:  result_o = lui_i;
            WB_MEM:  result_o = mem_i;
            WB_LINK: result_o = link_i;
            default: result_o = alu_i;
        endcase
    end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage and 32x32 register file. The selected result is staged in a
// one-entry pending register and committed to the array on the next edge.
// Optional macro WB_BYPASS_EN forwards the pending write to the read ports.
module wb_regfile
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    input  logic              wb_en,
    input  logic [1:0]        wb_sel,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] alu_res,
    input  logic [DATA_W-1:0] lui_res,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] link_addr,
    output logic              pend_valid,
    output logic [CNT_W-1:0]  wr_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    pend_t             pend_q, pend_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] wb_result;

    wb_result_mux u_mux (
        .sel_i    (wb_sel_e'(wb_sel)),
        .alu_i    (alu_res),
        .lui_i    (lui_res),
        .mem_i    (mem_data),
        .link_i   (link_addr),
        .result_o (wb_result)
    );

    // Capture the writeback request; writes to $0 are dropped here.
    always_comb begin
        pend_d       = pend_q;
        pend_d.valid = wb_en && (wb_addr != REG_ZERO);
        pend_d.addr  = wb_addr;
        pend_d.data  = wb_result;
    end

    // Count committed writes, holding at the maximum.
    always_comb begin
        cnt_d = cnt_q;
        if (pend_q.valid && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Pending register, counter and array commit; reset discards a pending write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (pend_q.valid) begin
                regs_q[pend_q.addr] <= pend_q.data;
            end
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    // Read ports: $0 reads zero, optionally forward the pending write, else the array.
    always_comb begin
        rs_data = regs_q[rs_addr];
        rt_data = regs_q[rt_addr];
`ifdef WB_BYPASS_EN
        if (pend_q.valid && (rs_addr == pend_q.addr)) begin
            rs_data = pend_q.data;
        end
        if (pend_q.valid && (rt_addr == pend_q.addr)) begin
            rt_data = pend_q.data;
        end
`endif
        if (rs_addr == REG_ZERO) begin
            rs_data = '0;
        end
        if (rt_addr == REG_ZERO) begin
            rt_data = '0;
        end
    end

    assign pend_valid = pend_q.valid;
    assign wr_count   = cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: a behavioural model of the register file
// checked every cycle, plus directed vectors with literal expectations.
module tb_wb_regfile;
    import mips_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] rs_addr, rt_addr, wb_addr;
    logic [DATA_W-1:0] rs_data, rt_data;
    logic              wb_en;
    logic [1:0]        wb_sel;
    logic [DATA_W-1:0] alu_res, lui_res, mem_data, link_addr;
    logic              pend_valid;
    logic [CNT_W-1:0]  wr_count;

    int n_pass  = 0;
    int n_total = 0;

    wb_regfile dut (
        .clk        (clk),
        .rst        (rst),
        .rs_addr    (rs_addr),
        .rt_addr    (rt_addr),
        .rs_data    (rs_data),
        .rt_data    (rt_data),
        .wb_en      (wb_en),
        .wb_sel     (wb_sel),
        .wb_addr    (wb_addr),
        .alu_res    (alu_res),
        .lui_res    (lui_res),
        .mem_data   (mem_data),
        .link_addr  (link_addr),
        .pend_valid (pend_valid),
        .wr_count   (wr_count)
    );

    always #5 clk = ~clk;

    // Model: architectural registers, the write in flight and the commit count.
    logic [DATA_W-1:0] m_regs [NUM_REGS];
    logic              m_inflight;
    logic [ADDR_W-1:0] m_inflight_reg;
    logic [DATA_W-1:0] m_inflight_val;
    int                m_count;
    bit                armed = 1'b0;

    function automatic logic [DATA_W-1:0] source_value(input logic [1:0] s);
        if (s == 2'd0) return alu_res;
        if (s == 2'd1) return lui_res;
        if (s == 2'd2) return mem_data;
        return link_addr;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) m_regs[i] <= '0;
            m_inflight     <= 1'b0;
            m_inflight_reg <= '0;
            m_inflight_val <= '0;
            m_count        <= 0;
            armed          <= 1'b1;
        end else begin
            if (m_inflight) begin
                m_regs[m_inflight_reg] <= m_inflight_val;
                m_count <= (m_count >= 65535) ? 65535 : m_count + 1;
            end
            m_inflight     <= wb_en && (wb_addr != 0);
            m_inflight_reg <= wb_addr;
            m_inflight_val <= source_value(wb_sel);
        end
    end

    function automatic logic [DATA_W-1:0] expect_read(input logic [ADDR_W-1:0] a);
        if (a == 0) return '0;
`ifdef WB_BYPASS_EN
        if (m_inflight && a == m_inflight_reg) return m_inflight_val;
`endif
        return m_regs[a];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (armed) begin
            chk("rs_data", rs_data, expect_read(rs_addr));
            chk("rt_data", rt_data, expect_read(rt_addr));
            chk("pend_valid", 32'(pend_valid), 32'(m_inflight));
            chk("wr_count", 32'(wr_count), 32'(m_count));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1; wb_en = 1'b0; wb_sel = 2'd0; wb_addr = '0;
        alu_res = '0; lui_res = '0; mem_data = '0; link_addr = '0;
        rs_addr = 5'd5; rt_addr = 5'd31;
        tick(); tick();
        settle();
        chk("reset rs", rs_data, 32'h0);
        chk("reset rt", rt_data, 32'h0);
        chk("reset pend", 32'(pend_valid), 32'h0);
        chk("reset count", 32'(wr_count), 32'h0);
        rst = 1'b0;

        // LUI write to r8
        wb_en = 1'b1; wb_sel = 2'b01; lui_res = 32'h0000_1234; wb_addr = 5'd8; rs_addr = 5'd8;
        tick();
        wb_en = 1'b0;
        settle();
        chk("lui pend", 32'(pend_valid), 32'h1);
`ifdef WB_BYPASS_EN
        chk("lui bypass", rs_data, 32'h0000_1234);
`else
        chk("lui not yet", rs_data, 32'h0);
`endif
        tick(); settle();
        chk("lui r8", rs_data, 32'h0000_1234);
        chk("lui count", 32'(wr_count), 32'h1);

        // write to $0 dropped
        wb_en = 1'b1; wb_sel = 2'b00; alu_res = 32'hDEAD_BEEF; wb_addr = 5'd0; rs_addr = 5'd0;
        tick();
        wb_en = 1'b0;
        settle();
        chk("r0 pend", 32'(pend_valid), 32'h0);
        chk("r0 read", rs_data, 32'h0);
        tick(); settle();
        chk("r0 count", 32'(wr_count), 32'h1);

        // back-to-back writes to r3
        rs_addr = 5'd3; rt_addr = 5'd3;
        wb_en = 1'b1; wb_addr = 5'd3; wb_sel = 2'b10; mem_data = 32'hA;
        tick();
        wb_sel = 2'b00; alu_res = 32'hB;
        tick();
        wb_sel = 2'b11; link_addr = 32'h0040_0008;
        tick();
        wb_en = 1'b0;
        tick(); settle();
        chk("b2b rs", rs_data, 32'h0040_0008);
        chk("b2b rt", rt_data, 32'h0040_0008);
        chk("b2b count", 32'(wr_count), 32'h4);

        // reset discards a pending write
        wb_en = 1'b1; wb_sel = 2'b00; alu_res = 32'h55; wb_addr = 5'd9; rs_addr = 5'd9; rt_addr = 5'd8;
        tick();
        wb_en = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        chk("rst r9", rs_data, 32'h0);
        chk("rst r8", rt_data, 32'h0);
        chk("rst count", 32'(wr_count), 32'h0);

        // saturation of the commit counter
        rs_addr = 5'd1; rt_addr = 5'd2;
        wb_en = 1'b1; wb_addr = 5'd1; wb_sel = 2'b00;
        for (int i = 0; i < 65534; i++) begin
            alu_res = 32'(i);
            tick();
        end
        wb_en = 1'b0;
        tick(); tick(); settle();
        chk("sat pre", 32'(wr_count), 32'h0000_FFFE);
        chk("sat r1", rs_data, 32'd65533);
        wb_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            alu_res = 32'h100 + 32'(i);
            tick();
        end
        wb_en = 1'b0;
        tick(); tick(); settle();
        chk("sat hold", 32'(wr_count), 32'h0000_FFFF);
        chk("sat r1 last", rs_data, 32'h102);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
